fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_rr_arb2.sv | 64 ++++++
 rtl/fb_arbiter.sv | 158 +++++++++++++++
 tb/tb_fb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel type and requester identifiers for the
// framebuffer port arbiter.
package fb_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int PIX_W     = 12;

  // RGB444 pixel: {R[11:8], G[7:4], B[3:0]}
  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_VGA  = 2'd1,
    REQ_WR0  = 2'd2,
    REQ_WR1  = 2'd3
  } req_id_t;

  function automatic logic addr_in_fb(input logic [31:0] addr);
    return addr < 32'(FB_DEPTH);
  endfunction

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-writer round-robin selector with per-writer starvation counters; a
// starved writer is allowed to take the port even while VGA is requesting.
module fb_rr_arb2
  import fb_pkg::*;
#(
  parameter int STARVE_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       vga_req,
  output logic [1:0] gnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic             rr_ptr_q, rr_ptr_d;
  logic [1:0][7:0]  wait_q, wait_d;
  logic [1:0]       starved;
  logic [1:0]       rr_pick;

  assign rr_pick = rr_ptr_q ? 2'b10 : 2'b01;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      starved[i] = req[i] && (wait_q[i] == LIMIT);
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (starved == 2'b11)       gnt = rr_pick;
      else if (starved != 2'b00)  gnt = starved;
      else if (!vga_req) begin
        if (req == 2'b11)         gnt = rr_pick;
        else                      gnt = req;
      end
    end
  end

  // Counters saturate at the limit so a starved writer stays starved until served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt[0])      rr_ptr_d = 1'b1;
    else if (gnt[1]) rr_ptr_d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_d[i] = wait_q[i];
      if (!req[i] || gnt[i])      wait_d[i] = 8'd0;
      else if (wait_q[i] != LIMIT) wait_d[i] = wait_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wait_q   <= wait_d;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer single-port arbiter: VGA fetch versus two pixel writers.
// Define FB_ARB_STATS_EN to add grant/miss statistics counters.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int AW           = 19,
  parameter int DW           = 12,
  parameter int STARVE_LIMIT = 15
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_miss,
  input  logic          wr0_req,
  input  logic [AW-1:0] wr0_addr,
  input  logic [DW-1:0] wr0_data,
  output logic          wr0_gnt,
  input  logic          wr1_req,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  output logic          wr1_gnt,
  output logic          wr_oob,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]   stat_vga_grants,
  output logic [31:0]   stat_wr_grants,
  output logic [31:0]   stat_vga_misses
`endif
);

  logic [1:0]    wr_gnt;
  req_id_t       sel_id;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_in_fb;

  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          wr_oob_q, wr_oob_d;
  logic [1:0]    rd_pipe_q, rd_pipe_d;

  fb_rr_arb2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_rr_arb2 (
    .clk     (CLK100MHZ),
    .reset   (reset),
    .req     ({wr1_req, wr0_req}),
    .vga_req (vga_req),
    .gnt     (wr_gnt)
  );

  assign vga_gnt  = !reset && vga_req && (wr_gnt == 2'b00);
  assign vga_miss = !reset && vga_req && !vga_gnt;
  assign wr0_gnt  = wr_gnt[0];
  assign wr1_gnt  = wr_gnt[1];

  assign w_addr  = wr_gnt[1] ? wr1_addr : wr0_addr;
  assign w_data  = wr_gnt[1] ? wr1_data : wr0_data;
  assign w_in_fb = addr_in_fb(32'(w_addr));

  always_comb begin
    sel_id = REQ_NONE;
    if (vga_gnt)        sel_id = REQ_VGA;
    else if (wr_gnt[0]) sel_id = REQ_WR0;
    else if (wr_gnt[1]) sel_id = REQ_WR1;
  end

  // Address/data hold their last value when idle; only mem_en/mem_we qualify them.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_oob_d    = 1'b0;
    rd_pipe_d   = {rd_pipe_q[0], vga_gnt};
    case (sel_id)
      REQ_VGA: begin
        mem_en_d   = 1'b1;
        mem_addr_d = vga_addr;
      end
      REQ_WR0, REQ_WR1: begin
        if (w_in_fb) begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = w_addr;
          mem_wdata_d = w_data;
        end else begin
          wr_oob_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_oob_q    <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_oob_q    <= wr_oob_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wr_oob     = wr_oob_q;
  assign vga_rvalid = rd_pipe_q[1];
  assign vga_rdata  = rd_pipe_q[1] ? mem_rdata : '0;

`ifdef FB_ARB_STATS_EN
  logic [31:0] stat_vga_grants_q, stat_vga_grants_d;
  logic [31:0] stat_wr_grants_q, stat_wr_grants_d;
  logic [31:0] stat_vga_misses_q, stat_vga_misses_d;

  always_comb begin
    stat_vga_grants_d = stat_vga_grants_q + {31'd0, vga_gnt};
    stat_wr_grants_d  = stat_wr_grants_q + {31'd0, (wr_gnt != 2'b00)};
    stat_vga_misses_d = stat_vga_misses_q + {31'd0, vga_miss};
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      stat_vga_grants_q <= '0;
      stat_wr_grants_q  <= '0;
      stat_vga_misses_q <= '0;
    end else begin
      stat_vga_grants_q <= stat_vga_grants_d;
      stat_wr_grants_q  <= stat_wr_grants_d;
      stat_vga_misses_q <= stat_vga_misses_d;
    end
  end

  assign stat_vga_grants = stat_vga_grants_q;
  assign stat_wr_grants  = stat_wr_grants_q;
  assign stat_vga_misses = stat_vga_misses_q;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: framebuffer memory model, cycle-level
// arbitration model with a per-cycle compare, and directed scenarios.
module tb_fb_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 12;
  localparam int LIM   = 15;
  localparam int DEPTH = 307200;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt, vga_rvalid, vga_miss;
  logic [DW-1:0] vga_rdata;
  logic          wr0_req, wr1_req, wr0_gnt, wr1_gnt, wr_oob;
  logic [AW-1:0] wr0_addr, wr1_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef FB_ARB_STATS_EN
  logic [31:0]   stat_vga_grants, stat_wr_grants, stat_vga_misses;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .vga_miss   (vga_miss),
    .wr0_req    (wr0_req),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr0_gnt    (wr0_gnt),
    .wr1_req    (wr1_req),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .wr1_gnt    (wr1_gnt),
    .wr_oob     (wr_oob),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef FB_ARB_STATS_EN
    ,
    .stat_vga_grants (stat_vga_grants),
    .stat_wr_grants  (stat_wr_grants),
    .stat_vga_misses (stat_vga_misses)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] init_pix(input int i);
    return 12'(i * 37 + 5);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Framebuffer: 1-cycle read latency, aliased to 1024 words
  logic [DW-1:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= init_pix(i);
    mem_rdata <= '0;
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr[9:0]];
      end
    end
  end

  // Cycle model: decide this cycle's winner from the rules, then predict what
  // the registered outputs and read pipeline will show next cycle.
  initial begin
    int            win;
    int            wt [2];
    int            rr;
    logic          st0, st1, rq;
    logic          e_en, e_we, e_oob, rv1, rv2;
    logic [AW-1:0] e_addr, a;
    logic [DW-1:0] e_wdata, d, rd1, rd2;
    logic [DW-1:0] shadow [0:1023];
    int            vga_cnt;
    for (int i = 0; i < 1024; i++) shadow[i] = init_pix(i);
    wt[0] = 0; wt[1] = 0; rr = 0;
    e_en = 0; e_we = 0; e_oob = 0; rv1 = 0; rv2 = 0;
    e_addr = '0; e_wdata = '0; rd1 = '0; rd2 = '0; vga_cnt = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      win = -1;
      if (!reset) begin
        st0 = wr0_req && (wt[0] >= LIM);
        st1 = wr1_req && (wt[1] >= LIM);
        if (st0 && st1)               win = rr;
        else if (st0)                 win = 0;
        else if (st1)                 win = 1;
        else if (vga_req)             win = 2;
        else if (wr0_req && wr1_req)  win = rr;
        else if (wr0_req)             win = 0;
        else if (wr1_req)             win = 1;
      end
      chk("vga_gnt", 32'(vga_gnt), 32'(win == 2));
      chk("wr0_gnt", 32'(wr0_gnt), 32'(win == 0));
      chk("wr1_gnt", 32'(wr1_gnt), 32'(win == 1));
      chk("vga_miss", 32'(vga_miss), 32'(!reset && vga_req && win != 2));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("wr_oob", 32'(wr_oob), 32'(e_oob));
      if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("vga_rvalid", 32'(vga_rvalid), 32'(rv2));
      chk("vga_rdata", 32'(vga_rdata), rv2 ? 32'(rd2) : 32'd0);
      if (reset) begin
        wt[0] = 0; wt[1] = 0; rr = 0;
        e_en = 0; e_we = 0; e_oob = 0; rv1 = 0; rv2 = 0; vga_cnt = 0;
      end else begin
        rv2 = rv1; rd2 = rd1;
        rv1 = (win == 2);
        e_en = 0; e_we = 0; e_oob = 0;
        if (win == 2) begin
          rd1 = shadow[vga_addr[9:0]];
          e_en = 1; e_addr = vga_addr;
          vga_cnt++;
        end else if (win >= 0) begin
          a = (win == 1) ? wr1_addr : wr0_addr;
          d = (win == 1) ? wr1_data : wr0_data;
          if (int'(a) >= DEPTH) e_oob = 1;
          else begin
            e_en = 1; e_we = 1; e_addr = a; e_wdata = d;
            shadow[a[9:0]] = d;
          end
          rr = 1 - win;
        end
        for (int w = 0; w < 2; w++) begin
          rq = (w == 1) ? wr1_req : wr0_req;
          if (!rq || win == w) wt[w] = 0;
          else if (wt[w] < LIM) wt[w]++;
        end
      end
`ifdef FB_ARB_STATS_EN
      if (reset === 1'b0) chk("stat_vga_grants", stat_vga_grants, 32'(vga_cnt));
`endif
    end
  end

  initial begin
    logic [5:0] seq;
    int         first;
    logic       miss_at;
    reset = 1; vga_req = 0; vga_addr = '0;
    wr0_req = 0; wr0_addr = '0; wr0_data = '0;
    wr1_req = 0; wr1_addr = '0; wr1_data = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_vga_rvalid", 32'(vga_rvalid), 0);
    chk("rst_vga_rdata", 32'(vga_rdata), 0);
    chk("rst_wr_oob", 32'(wr_oob), 0);
    cyc(); reset = 0;
    repeat (2) cyc();

    // VGA alone, addresses 0..9 back to back
    for (int i = 0; i < 10; i++) begin
      vga_req = 1; vga_addr = AW'(i);
      @(negedge clk);
      chk("t1_gnt", 32'(vga_gnt), 1);
      if (i == 2) chk("t1_rdata0", 32'(vga_rdata), 32'h005);
      if (i == 3) chk("t1_rdata1", 32'(vga_rdata), 32'h02A);
      cyc();
    end
    vga_req = 0;
    repeat (3) cyc();

    // Both writers continuously: strict alternation starting with wr0
    seq = '0;
    for (int k = 0; k < 6; k++) begin
      wr0_req = 1; wr1_req = 1;
      wr0_addr = AW'(100 + k); wr0_data = 12'hA00 + 12'(k);
      wr1_addr = AW'(200 + k); wr1_data = 12'hB00 + 12'(k);
      @(negedge clk);
      seq[k] = wr1_gnt;
      if (k > 0) chk("t2_mem_we", 32'(mem_we), 1);
      cyc();
    end
    chk("t2_seq", 32'(seq), 32'b101010);
    wr0_req = 0; wr1_req = 0;
    cyc();

    // Read back written and untouched locations
    vga_req = 1; vga_addr = AW'(102); cyc();
    vga_addr = AW'(101); cyc();
    vga_addr = AW'(201);
    @(negedge clk); chk("t2_rd102", 32'(vga_rdata), 32'hA02);
    cyc(); vga_req = 0;
    @(negedge clk); chk("t2_rd101", 32'(vga_rdata), 32'hE9E);
    cyc();
    @(negedge clk); chk("t2_rd201", 32'(vga_rdata), 32'hB01);
    repeat (2) cyc();

    // Starvation: VGA continuous, wr0 held
    vga_req = 1; vga_addr = AW'(7);
    wr0_req = 1; wr0_addr = AW'(300); wr0_data = 12'h123;
    first = 0; miss_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (wr0_gnt) begin
        first = k; miss_at = vga_miss;
        break;
      end
      cyc();
    end
    chk("t3_first_gnt_cycle", 32'(first), 16);
    chk("t3_vga_miss", 32'(miss_at), 1);
    cyc();
    @(negedge clk);
    chk("t3_vga_resumes", 32'(vga_gnt), 1);
    cyc(); vga_req = 0; wr0_req = 0;
    repeat (3) cyc();

    // Out-of-range write from wr1
    wr1_req = 1; wr1_addr = AW'(DEPTH); wr1_data = 12'hFFF;
    @(negedge clk); chk("t4_wr1_gnt", 32'(wr1_gnt), 1);
    cyc(); wr1_req = 0;
    @(negedge clk);
    chk("t4_wr_oob", 32'(wr_oob), 1);
    chk("t4_mem_we", 32'(mem_we), 0);
    chk("t4_mem_en", 32'(mem_en), 0);
    cyc();

    // Leave rr_ptr pointing at wr1, then reset right after a VGA grant
    wr0_req = 1; wr0_addr = AW'(5); wr0_data = 12'h555;
    cyc(); wr0_req = 0;
    cyc();
    vga_req = 1; vga_addr = AW'(3);
    @(negedge clk); chk("t5_vga_gnt", 32'(vga_gnt), 1);
    cyc(); reset = 1; wr0_req = 1;
    @(negedge clk);
    chk("t5_rst_vga_gnt", 32'(vga_gnt), 0);
    chk("t5_rst_wr0_gnt", 32'(wr0_gnt), 0);
    cyc();
    @(negedge clk);
    chk("t5_no_rvalid", 32'(vga_rvalid), 0);
    chk("t5_mem_en", 32'(mem_en), 0);
    chk("t5_mem_we", 32'(mem_we), 0);
    chk("t5_mem_addr", 32'(mem_addr), 0);
    chk("t5_mem_wdata", 32'(mem_wdata), 0);
    chk("t5_vga_rdata", 32'(vga_rdata), 0);
    cyc(); reset = 0; vga_req = 0;
    wr0_req = 1; wr1_req = 1; wr0_addr = AW'(10); wr1_addr = AW'(11);
    @(negedge clk);
    chk("t5_rr_wr0_first", 32'(wr0_gnt), 1);
    chk("t5_rr_wr1_wait", 32'(wr1_gnt), 0);
    chk("t5_still_no_rvalid", 32'(vga_rvalid), 0);
    cyc(); wr0_req = 0; wr1_req = 0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
